// File: rtl/func_eval_pkg.sv
// Shared types and default widths for the table-interpolating function evaluator.
package func_eval_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    INTERP  = 3'd3,
    OUT     = 3'd4
  } fe_state_e;

  localparam logic [1:0] FN_0 = 2'd0;
  localparam logic [1:0] FN_1 = 2'd1;
  localparam logic [1:0] FN_2 = 2'd2;
  localparam logic [1:0] FN_3 = 2'd3;

  localparam int FE_X_W      = 8;
  localparam int FE_SEG_BITS = 4;
  localparam int FE_TW       = 16;
  localparam int FE_TI       = 8;
  localparam int FE_FB       = FE_X_W - FE_SEG_BITS;
  localparam int FE_TF       = FE_TW - FE_TI;
  localparam int FE_AW       = 2 + FE_SEG_BITS;

endpackage

// File: rtl/func_eval_unit_interp.sv
// Combinational linear interpolation y = a + ((b-a)*t >>> FB).
module fe_interp_dp
  import func_eval_pkg::*;
#(
  parameter int TW = FE_TW,
  parameter int FB = FE_FB
) (
  input  logic [TW-1:0] a,
  input  logic [TW-1:0] b,
  input  logic [FB-1:0] t,
  output logic [TW-1:0] y
);

  logic signed [TW:0]    diff;
  logic signed [TW+FB:0] prod;
  logic signed [TW+FB:0] sh;

  assign diff = $signed({1'b0, b}) - $signed({1'b0, a});
  assign prod = $signed({{FB{diff[TW]}}, diff})
              * $signed({{(TW+1){1'b0}}, t});
  // result lies between a and b, so the low TW bits are exact
  assign sh   = prod >>> FB;
  assign y    = a + sh[TW-1:0];

endmodule

// File: rtl/func_eval_unit.sv
// Four-function table evaluator with ROM fetch and linear interpolation.
// Optional partial scan chain on state/A/B via `define SCAN_CHAIN_EN.
module func_eval_unit
  import func_eval_pkg::*;
#(
  parameter int X_W      = FE_X_W,
  parameter int SEG_BITS = FE_SEG_BITS,
  parameter int TW       = FE_TW,
  parameter int TI       = FE_TI
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            func,
  input  logic [X_W-1:0]        x,
  output logic                  busy,
  output logic                  done,
  output logic [SEG_BITS+1:0]   addr,
  input  logic [TW-1:0]         tableData,
`ifdef SCAN_CHAIN_EN
  input  logic                  NbarT,
  input  logic                  si,
  output logic                  so,
`endif
  output logic [TI-1:0]         resultIPart,
  output logic [TW-TI-1:0]      resultFPart
);

  localparam int FB = X_W - SEG_BITS;
  localparam int TF = TW - TI;

  fe_state_e           state;
  logic [1:0]          f_q;
  logic [SEG_BITS-1:0] i_q;
  logic [FB-1:0]       t_q;
  logic [TW-1:0]       a_q;
  logic [TW-1:0]       b_q;
  logic [TW-1:0]       res_q;
  logic [TW-1:0]       b_nxt;
  logic [TW-1:0]       y;
  logic                last;

  assign last  = (i_q == {SEG_BITS{1'b1}});
  assign b_nxt = last ? a_q : tableData;

  fe_interp_dp #(.TW(TW), .FB(FB)) u_dp (
    .a (a_q),
    .b (b_nxt),
    .t (t_q),
    .y (y)
  );

`ifdef SCAN_CHAIN_EN
  localparam int CL = 3 + 2*TW;
  logic [CL-1:0] chain;
  logic [CL-1:0] chain_sh;
  assign chain    = {state, a_q, b_q};
  assign chain_sh = {si, chain[CL-1:1]};
  assign so       = b_q[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      addr  <= '0;
      f_q   <= '0;
      i_q   <= '0;
      t_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end
`ifdef SCAN_CHAIN_EN
    else if (NbarT) begin
      state <= fe_state_e'(chain_sh[CL-1:CL-3]);
      a_q   <= chain_sh[2*TW-1:TW];
      b_q   <= chain_sh[TW-1:0];
      done  <= 1'b0;
    end
`endif
    else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            f_q   <= func;
            i_q   <= x[X_W-1:FB];
            t_q   <= x[FB-1:0];
            addr  <= {func, x[X_W-1:FB]};
            busy  <= 1'b1;
            state <= FETCH_A;
          end
        end
        FETCH_A: begin
          // clamp at the top segment instead of wrapping
          addr  <= last ? {f_q, i_q}
                        : {f_q, i_q + SEG_BITS'(1)};
          state <= FETCH_B;
        end
        FETCH_B: begin
          a_q   <= tableData;
          state <= INTERP;
        end
        INTERP: begin
          b_q   <= b_nxt;
          res_q <= y;
          done  <= 1'b1;
          state <= OUT;
        end
        OUT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign resultIPart = res_q[TW-1:TF];
  assign resultFPart = res_q[TF-1:0];

endmodule
